// File: rtl/da_fir_pkg.sv
// Shared types and default sizing for the bit-serial distributed-arithmetic FIR sequencer.
package da_fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int TAPS_DEF     = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int SUM_W_DEF    = 20;
  localparam int PIPE_LAT_DEF = 2;

  // Accumulator must hold a SUM_W partial sum shifted by up to DATA_W-1 planes.
  function automatic int acc_width(input int sum_w, input int data_w);
    return sum_w + data_w;
  endfunction

endpackage

// File: rtl/da_fir_bitserial_seq_if.sv
// Sample, LUT and result handshakes of the DA FIR sequencer; master drives samples, sums and out_ready.
interface da_fir_bitserial_seq_if #(
  parameter int TAPS   = da_fir_pkg::TAPS_DEF,
  parameter int DATA_W = da_fir_pkg::DATA_W_DEF,
  parameter int SUM_W  = da_fir_pkg::SUM_W_DEF
);
  import da_fir_pkg::*;

  localparam int ACC_W = acc_width(SUM_W, DATA_W);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     addr_valid;
  logic [TAPS-1:0]          lut_addr;
  logic                     sum_valid;
  logic signed [SUM_W-1:0]  sum_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     busy;
  logic                     err;

  modport master (
    output in_valid, in_data, sum_valid, sum_data, out_ready,
    input  in_ready, addr_valid, lut_addr, out_valid, out_data, busy, err
  );

  modport slave (
    input  in_valid, in_data, sum_valid, sum_data, out_ready,
    output in_ready, addr_valid, lut_addr, out_valid, out_data, busy, err
  );

endinterface

// File: rtl/da_fir_delay_line.sv
// TAPS-deep sample shift register; presents one bit-plane (bit bit_idx of every tap) per cycle.
module da_fir_delay_line
  import da_fir_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BIT_W  = $clog2(DATA_W_DEF)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  input  logic [BIT_W-1:0]  bit_idx,
  output logic [TAPS-1:0]   plane
);

  logic [DATA_W-1:0] taps [TAPS];

  // Tap 0 holds the newest sample; the oldest tap falls off the end.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
    end
  end

  always_comb begin
    plane = '0;
    for (int k = 0; k < TAPS; k++) plane[k] = taps[k][bit_idx];
  end

endmodule

// File: rtl/da_fir_bitserial_seq.sv
// Bit-serial DA FIR sequencer: issues LSB-first LUT addresses, shift-accumulates the returned
// partial sums (sign plane subtracted) and hands the result downstream.
module da_fir_bitserial_seq #(
  parameter int TAPS     = da_fir_pkg::TAPS_DEF,
  parameter int DATA_W   = da_fir_pkg::DATA_W_DEF,
  parameter int SUM_W    = da_fir_pkg::SUM_W_DEF,
  parameter int PIPE_LAT = da_fir_pkg::PIPE_LAT_DEF
) (
  input logic                   clk,
  input logic                   rst,
  da_fir_bitserial_seq_if.slave bus
);
  import da_fir_pkg::*;

  localparam int ACC_W = acc_width(SUM_W, DATA_W);
  localparam int BIT_W = $clog2(DATA_W);

  state_e                  state;
  logic [BIT_W-1:0]        bit_cnt;
  logic signed [ACC_W-1:0] acc;
  logic                    in_ready_q;
  logic                    addr_valid_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    err_q;
  logic [PIPE_LAT-1:0]     exp_vld;
  logic [BIT_W-1:0]        exp_bit [PIPE_LAT];
  logic [PIPE_LAT-1:0]     drop_vld;
  logic [TAPS-1:0]         plane;
  logic                    accept;
  logic                    expected;
  logic                    last_bit;
  logic                    discard;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] sum_weighted;

  assign accept       = bus.in_valid && in_ready_q;
  assign expected     = exp_vld[PIPE_LAT-1];
  assign discard      = drop_vld[PIPE_LAT-1];
  assign last_bit     = (exp_bit[PIPE_LAT-1] == BIT_W'(DATA_W-1));
  assign sum_ext      = {{(ACC_W-SUM_W){bus.sum_data[SUM_W-1]}}, bus.sum_data};
  assign sum_weighted = sum_ext << exp_bit[PIPE_LAT-1];

  da_fir_delay_line #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .BIT_W  (BIT_W)
  ) u_delay_line (
    .clk      (clk),
    .clear    (rst),
    .shift_en (accept),
    .din      (bus.in_data),
    .bit_idx  (bit_cnt),
    .plane    (plane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      in_ready_q   <= 1'b1;
      addr_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state        <= ITER;
            bit_cnt      <= '0;
            in_ready_q   <= 1'b0;
            addr_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ITER: begin
          if (bit_cnt == BIT_W'(DATA_W-1)) begin
            state        <= DRAIN;
            addr_valid_q <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        DRAIN: begin
          // The sign-plane sum is accumulated on this same edge, so acc is final in DONE.
          if (expected && last_bit) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_vld <= '0;
      for (int i = 0; i < PIPE_LAT; i++) exp_bit[i] <= '0;
      acc   <= '0;
      err_q <= 1'b0;
    end else begin
      exp_vld[0] <= addr_valid_q;
      exp_bit[0] <= bit_cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        exp_vld[i] <= exp_vld[i-1];
        exp_bit[i] <= exp_bit[i-1];
      end
      if (accept) begin
        acc <= '0;
      end else if (bus.sum_valid && expected) begin
        acc <= last_bit ? (acc - sum_weighted) : (acc + sum_weighted);
      end
      if ((bus.sum_valid && !expected && !discard) || (expected && !bus.sum_valid)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Remembers which sums were still in flight when reset hit, so their late returns are
  // silently dropped instead of flagging a protocol error.
  always_ff @(posedge clk) begin
    drop_vld[0] <= rst && addr_valid_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      drop_vld[i] <= drop_vld[i-1] || (rst && exp_vld[i-1]);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.lut_addr   = addr_valid_q ? plane : '0;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = acc;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_da_fir_bitserial_seq.sv
// Bench for da_fir_bitserial_seq: LUT model answers every address after PIPE_LAT cycles and a
// plain dot-product model of the filter supplies the expected outputs.
module tb_da_fir_bitserial_seq;

  localparam int TAPS     = 16;
  localparam int DATA_W   = 16;
  localparam int SUM_W    = 20;
  localparam int PIPE_LAT = 2;
  localparam int LAT      = DATA_W + PIPE_LAT;
  localparam int PERIOD   = DATA_W + PIPE_LAT + 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     tests = 0;
  int     fails = 0;
  longint cycle = 0;
  longint last_accept = 0;
  longint last_out = 0;
  longint taps_m [TAPS];
  int     h [TAPS];
  bit     inject_spur = 1'b0;
  bit     drop_one = 1'b0;

  da_fir_bitserial_seq_if #(.TAPS(TAPS), .DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

  da_fir_bitserial_seq #(
    .TAPS     (TAPS),
    .DATA_W   (DATA_W),
    .SUM_W    (SUM_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // External LUT + compressor tree: every cycle's address is answered PIPE_LAT cycles later.
  initial begin : lut_model
    bit     vq [$];
    longint sq [$];
    bit     v;
    longint s;
    bus.sum_valid = 1'b0;
    bus.sum_data  = '0;
    forever begin
      @(negedge clk);
      s = 0;
      for (int k = 0; k < TAPS; k++)
        if (bus.addr_valid && bus.lut_addr[k]) s += longint'(h[k]);
      vq.push_back(bus.addr_valid);
      sq.push_back(s);
      v = 1'b0;
      s = 0;
      if (vq.size() > PIPE_LAT) begin
        v = vq.pop_front();
        s = sq.pop_front();
      end
      if (inject_spur && !v) begin
        v = 1'b1;
        s = 123;
        inject_spur = 1'b0;
      end
      if (drop_one && v) begin
        v = 1'b0;
        drop_one = 1'b0;
      end
      bus.sum_valid = v;
      bus.sum_data  = SUM_W'(s);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) taps_m[k] = 0;
  endtask

  task automatic set_coeffs_ramp();
    for (int k = 0; k < TAPS; k++) h[k] = k + 1;
  endtask

  function automatic longint model_out();
    longint y = 0;
    for (int k = 0; k < TAPS; k++) y += longint'(h[k]) * taps_m[k];
    return y;
  endfunction

  function automatic longint model_plane(input int b);
    longint p = longint'(1) << TAPS;
    for (int k = 0; k < TAPS; k++) p |= ((taps_m[k] >>> b) & 1) << k;
    return p;
  endfunction

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] x);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("in_ready_wait", longint'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    tick();
    last_accept  = cycle;
    bus.in_valid = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) taps_m[k] = taps_m[k-1];
    taps_m[0] = longint'($signed(x));
  endtask

  task automatic run_sample(input logic [DATA_W-1:0] x, input int stall,
                            input bit chk_data, input bit err_exp);
    int     n = 0;
    longint held;
    bus.out_ready = (stall == 0);
    applyStimulus(x);
    for (int b = 0; b < DATA_W; b++) begin
      if (b > 0) tick();
      checkOutput($sformatf("plane%0d", b), longint'({bus.addr_valid, bus.lut_addr}), model_plane(b));
    end
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("out_valid_wait", longint'(bus.out_valid), 1);
    checkOutput("latency", cycle - last_accept, LAT);
    last_out = longint'($signed(bus.out_data));
    if (chk_data) checkOutput("out_data", last_out, model_out());
    if (stall > 0) begin
      held = last_out;
      for (int s = 0; s < stall; s++) begin
        bus.in_valid = (s == 1);
        bus.in_data  = DATA_W'($urandom);
        tick();
        bus.in_valid = 1'b0;
        checkOutput("bp_out_valid", longint'(bus.out_valid), 1);
        checkOutput("bp_hold", longint'($signed(bus.out_data)), held);
        checkOutput("bp_in_ready", longint'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
    end
    tick();
    checkOutput("after_handshake", longint'({bus.out_valid, bus.in_ready, bus.busy}), 2);
    checkOutput("err", longint'(bus.err), longint'(err_exp));
  endtask

  initial begin : main
    longint prev;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    set_coeffs_ramp();
    model_clear();

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_in_ready",   longint'(bus.in_ready), 1);
    checkOutput("rst_out_valid",  longint'(bus.out_valid), 0);
    checkOutput("rst_out_data",   longint'($signed(bus.out_data)), 0);
    checkOutput("rst_err",        longint'(bus.err), 0);
    checkOutput("rst_busy",       longint'(bus.busy), 0);
    checkOutput("rst_lut_addr",   longint'(bus.lut_addr), 0);
    checkOutput("rst_addr_valid", longint'(bus.addr_valid), 0);
    rst = 1'b0;
    tick();

    // Impulse response walks out the ramp coefficients 1..16.
    prev = 0;
    for (int i = 0; i < TAPS; i++) begin
      run_sample((i == 0) ? DATA_W'(1) : DATA_W'(0), 0, 1'b1, 1'b0);
      checkOutput("impulse_value", last_out, longint'(i + 1));
      if (i > 0) checkOutput("throughput", last_accept - prev, PERIOD);
      prev = last_accept;
    end

    // Sign plane.
    reset_pulse();
    run_sample(16'hFFFF, 0, 1'b1, 1'b0);
    checkOutput("minus_one", last_out, -1);
    for (int k = 0; k < TAPS; k++) h[k] = 1;
    for (int i = 0; i < TAPS; i++) run_sample(16'h8000, 0, 1'b1, 1'b0);
    checkOutput("most_negative", last_out, -524288);

    // Backpressure in DONE with an ignored in_valid pulse.
    set_coeffs_ramp();
    run_sample(16'h1234, 5, 1'b1, 1'b0);
    run_sample(16'h0F0F, 0, 1'b1, 1'b0);

    // Spurious sum while idle.
    reset_pulse();
    checkOutput("err_clear", longint'(bus.err), 0);
    inject_spur = 1'b1;
    tick();
    checkOutput("err_spur", longint'(bus.err), 1);
    run_sample(16'h0007, 0, 1'b1, 1'b1);
    run_sample(16'hFFF0, 0, 1'b1, 1'b1);

    // Dropped sum during ITER.
    reset_pulse();
    checkOutput("err_clear2", longint'(bus.err), 0);
    drop_one = 1'b1;
    run_sample(16'h0055, 0, 1'b0, 1'b1);

    // Reset in the middle of ITER, at bit-plane 7.
    reset_pulse();
    applyStimulus(DATA_W'($urandom));
    for (int b = 1; b <= 7; b++) tick();
    checkOutput("plane7", longint'({bus.addr_valid, bus.lut_addr}), model_plane(7));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    checkOutput("mid_rst_addr_valid", longint'(bus.addr_valid), 0);
    checkOutput("mid_rst_lut_addr",   longint'(bus.lut_addr), 0);
    checkOutput("mid_rst_busy",       longint'(bus.busy), 0);
    checkOutput("mid_rst_in_ready",   longint'(bus.in_ready), 1);
    checkOutput("mid_rst_out_data",   longint'($signed(bus.out_data)), 0);
    repeat (PIPE_LAT + 2) tick();
    checkOutput("late_sums_no_err", longint'(bus.err), 0);
    run_sample(DATA_W'(1), 0, 1'b1, 1'b0);
    checkOutput("post_rst_impulse", last_out, 1);

    // Random samples, coefficients and stalls.
    for (int r = 0; r < 30; r++) begin
      if (r % 10 == 0)
        for (int k = 0; k < TAPS; k++) h[k] = int'($urandom_range(0, 1000)) - 500;
      run_sample(DATA_W'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
